// File: rtl/mode_counter_pkg.sv
// counter_pkg: boundary mode encoding and direction constants for mode_counter.
package counter_pkg;
   typedef enum logic [1:0] {
      MODE_WRAP   = 2'b00,
      MODE_SAT    = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/mode_counter_if.sv
// mode_counter_if: control inputs and status outputs of mode_counter.
interface mode_counter_if #(parameter int N = 8);
   import counter_pkg::*;
   logic enable, clear, load, up;
   logic [N-1:0] load_val, min, max, step, count;
   mode_t mode;
   logic at_max, at_min, dir_up, rollover, bound_err;
   modport master (
      output enable, clear, load, up, load_val, min, max, step, mode,
      input count, at_max, at_min, dir_up, rollover, bound_err
   );
   modport slave (
      input enable, clear, load, up, load_val, min, max, step, mode,
      output count, at_max, at_min, dir_up, rollover, bound_err
   );
endinterface

// File: rtl/mode_counter_prescaler.sv
// tick_prescaler: divides enabled cycles by PRESCALE; disabled cycles freeze the phase.
module tick_prescaler #(parameter int PRESCALE = 1) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic tick
);
   localparam int W = $clog2(PRESCALE) + 1;
   logic [W-1:0] cnt;
   assign tick = enable && cnt == W'(PRESCALE - 1);
   always_ff @(posedge clk)
      if (rst || restart) cnt <= '0;
      else if (enable) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/mode_counter.sv
// mode_counter: bounded up/down counter with wrap, saturate and bounce modes,
// parallel load, enable prescaler and a registered boundary-event pulse.
module mode_counter
   import counter_pkg::*;
#(
   parameter int N         = 8,
   parameter int PRESCALE  = 1,
   parameter int RESET_VAL = 0
) (
   input logic         clk,
   input logic         rst,
   mode_counter_if.slave bus
);
   logic [N-1:0] count, next_count, stepped, edge_val, wrap_val;
   logic [N:0] sum, diff;
   logic dir_q, next_dir, next_roll, rollover, tick, restart, bound_err, d, bounce, hit;
   assign bound_err = bus.min > bus.max;
   assign restart = !bound_err && (bus.clear || bus.load);
   assign bounce = bus.mode == MODE_BOUNCE;
   assign d = bounce ? dir_q : bus.up;
   tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk(clk), .rst(rst), .enable(bus.enable), .restart(restart), .tick(tick)
   );
   // one extra bit keeps carry/borrow visible so bounds never alias
   assign sum = {1'b0, count} + {1'b0, bus.step};
   assign diff = {1'b0, count} - {1'b0, bus.step};
   assign hit = d ? (bounce ? sum >= {1'b0, bus.max} : sum > {1'b0, bus.max})
                  : (diff[N] || (bounce ? diff[N-1:0] <= bus.min : diff[N-1:0] < bus.min));
   assign stepped = d ? sum[N-1:0] : diff[N-1:0];
   assign edge_val = d ? bus.max : bus.min;
   assign wrap_val = d ? bus.min : bus.max;
   always_comb begin
      next_count = count;
      next_dir = d;
      next_roll = 1'b0;
      if (bound_err) next_dir = dir_q;
      else if (bus.clear) next_count = bus.min;
      else if (bus.load)
         next_count = bus.load_val < bus.min ? bus.min : bus.load_val > bus.max ? bus.max : bus.load_val;
      else if (tick && bus.step != '0) begin
         if (count < bus.min || count > bus.max) next_count = wrap_val;
         else if (bus.mode == MODE_WRAP) begin
            next_count = hit ? wrap_val : stepped;
            next_roll = hit;
         end else if (bounce) begin
            next_count = hit ? edge_val : stepped;
            next_roll = hit;
            next_dir = hit ? !d : d;
         end else begin
            next_count = hit ? edge_val : stepped;
            next_roll = next_count == edge_val && count != edge_val;
         end
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         count <= N'(RESET_VAL);
         dir_q <= DIR_UP;
         rollover <= 1'b0;
      end else begin
         count <= next_count;
         dir_q <= next_dir;
         rollover <= next_roll;
      end
   assign bus.count = count;
   assign bus.at_max = count == bus.max;
   assign bus.at_min = count == bus.min;
   assign bus.dir_up = dir_q;
   assign bus.rollover = rollover;
   assign bus.bound_err = bound_err;
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: two instances (PRESCALE 1 and 3) driven in parallel and
// compared every cycle against an integer reference model.
module tb_mode_counter;
   import counter_pkg::*;
   localparam int N = 4;
   logic clk = 1'b0, rst;
   logic enable, clear, load, up;
   logic [N-1:0] load_val, min, max, step;
   logic [1:0] mode;
   logic [N-1:0] cnt [2];
   logic dirv [2], rov [2], amax [2], amin [2], berr [2];
   int total, bad;
   int mc [2], md [2], mr [2], mp [2];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : u
      mode_counter_if #(.N(N)) bus ();
      assign bus.enable = enable;
      assign bus.clear = clear;
      assign bus.load = load;
      assign bus.up = up;
      assign bus.load_val = load_val;
      assign bus.min = min;
      assign bus.max = max;
      assign bus.step = step;
      assign bus.mode = mode_t'(mode);
      assign cnt[g] = bus.count;
      assign dirv[g] = bus.dir_up;
      assign rov[g] = bus.rollover;
      assign amax[g] = bus.at_max;
      assign amin[g] = bus.at_min;
      assign berr[g] = bus.bound_err;
      mode_counter #(.N(N), .PRESCALE(g == 0 ? 1 : 3), .RESET_VAL(0)) dut (
         .clk(clk), .rst(rst), .bus(bus)
      );
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int ps, c, s, lo, hi, eff, t;
         bit tick, be;
         ps = k == 0 ? 1 : 3;
         if (rst) begin
            mc[k] = 0; md[k] = 1; mr[k] = 0; mp[k] = 0;
            continue;
         end
         lo = int'(min); hi = int'(max); c = mc[k];
         be = lo > hi;
         eff = mode == 2 ? md[k] : int'(up);
         tick = enable && mp[k] == ps - 1;
         if (!be && (clear || load)) mp[k] = 0;
         else if (enable) mp[k] = tick ? 0 : mp[k] + 1;
         mr[k] = 0;
         if (be) continue;
         md[k] = eff;
         if (clear) c = lo;
         else if (load) c = int'(load_val) < lo ? lo : int'(load_val) > hi ? hi : int'(load_val);
         else if (tick && step != 0) begin
            s = eff != 0 ? c + int'(step) : c - int'(step);
            if (c < lo || c > hi) c = eff != 0 ? lo : hi;
            else if (mode == 0) begin
               if (eff != 0 && s > hi) begin c = lo; mr[k] = 1; end
               else if (eff == 0 && s < lo) begin c = hi; mr[k] = 1; end
               else c = s;
            end else if (mode == 2) begin
               if (eff != 0 && s >= hi) begin c = hi; md[k] = 0; mr[k] = 1; end
               else if (eff == 0 && s <= lo) begin c = lo; md[k] = 1; mr[k] = 1; end
               else c = s;
            end else begin
               t = s > hi ? hi : s < lo ? lo : s;
               mr[k] = int'(t != c && t == (eff != 0 ? hi : lo));
               c = t;
            end
         end
         mc[k] = c;
      end
   endtask
   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("count%0d", k), 32'(cnt[k]), mc[k]);
         check($sformatf("dir_up%0d", k), 32'(dirv[k]), md[k]);
         check($sformatf("rollover%0d", k), 32'(rov[k]), mr[k]);
         check($sformatf("at_max%0d", k), 32'(amax[k]), 32'(mc[k] == int'(max)));
         check($sformatf("at_min%0d", k), 32'(amin[k]), 32'(mc[k] == int'(min)));
         check($sformatf("bound_err%0d", k), 32'(berr[k]), 32'(min > max));
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask
   initial begin
      int p1c [3] = '{5, 8, 2};
      int p1r [3] = '{0, 0, 1};
      logic [N-1:0] tmp;
      total = 0; bad = 0;
      rst = 1; enable = 0; clear = 0; load = 0; up = 1; mode = 0;
      load_val = 0; min = 0; max = 15; step = 1;
      cyc(); cyc();
      rst = 0;
      check("rst_count", 32'(cnt[0]), 0);
      check("rst_dir", 32'(dirv[0]), 1);
      mode = 0; up = 1; min = 2; max = 9; step = 3; clear = 1;
      cyc();
      clear = 0;
      check("p1_clear", 32'(cnt[0]), 2);
      enable = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("p1_count", 32'(cnt[0]), p1c[i]);
         check("p1_roll", 32'(rov[0]), p1r[i]);
      end
      enable = 0;
      mode = 1; up = 0; min = 0; max = 15; step = 4; load_val = 6; load = 1;
      cyc();
      load = 0; enable = 1;
      repeat (3) cyc();
      enable = 0;
      check("p2_count", 32'(cnt[0]), 0);
      check("p2_at_min", 32'(amin[0]), 1);
      mode = 0; up = 1; min = 1; max = 6; step = 2; load_val = 1; load = 1;
      cyc();
      load = 0; mode = 2; up = 0; enable = 1;
      repeat (8) cyc();
      enable = 0;
      check("p3_count", 32'(cnt[0]), 5);
      mode = 0; up = 1; min = 0; max = 15; step = 1; clear = 1;
      cyc();
      clear = 0; enable = 1;
      repeat (4) cyc();
      enable = 0;
      repeat (2) cyc();
      enable = 1;
      repeat (5) cyc();
      enable = 0;
      check("p4_prescaled", 32'(cnt[1]), 3);
      clear = 1; load = 1; enable = 1; min = 2; load_val = 12;
      cyc();
      check("p5_clear_wins", 32'(cnt[0]), 2);
      clear = 0; max = 9;
      cyc();
      load = 0;
      check("p5_load_clamp", 32'(cnt[0]), 9);
      min = 10;
      repeat (3) cyc();
      check("p5_bound_err", 32'(berr[0]), 1);
      check("p5_hold", 32'(cnt[0]), 9);
      enable = 0; min = 1; max = 6; step = 1; mode = 0; up = 0; load_val = 4; load = 1;
      cyc();
      load = 0; mode = 2; rst = 1;
      cyc();
      rst = 0;
      check("p6_rst_count", 32'(cnt[0]), 0);
      check("p6_rst_dir", 32'(dirv[0]), 1);
      enable = 1;
      cyc();
      check("p6_oor_count", 32'(cnt[0]), 1);
      check("p6_oor_roll", 32'(rov[0]), 0);
      for (int i = 0; i < 1500; i++) begin
         rst = $urandom_range(0, 60) == 0;
         clear = $urandom_range(0, 19) == 0;
         load = $urandom_range(0, 14) == 0;
         enable = $urandom_range(0, 9) < 7;
         up = 1'($urandom_range(0, 1));
         load_val = N'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            mode = 2'($urandom_range(0, 3));
            min = N'($urandom);
            max = N'($urandom);
            if ($urandom_range(0, 7) != 0 && min > max) begin
               tmp = min; min = max; max = tmp;
            end
            step = $urandom_range(0, 3) == 0 ? N'($urandom) : N'($urandom_range(0, 3));
         end
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Parametrised N-bit up/down counter; successor to the basic 4-bit wrap/hold counter. Adds runtime min/max bounds, programmable step, three boundary modes (wrap, saturate, bounce), parallel load, built-in enable prescaler and a registered boundary-event pulse for cascading. Shared building block for the FPGA test tops and later timers, scanners and display sequencers.

Parameters:
N, 8, counter width in bits; count range 0..2^N-1
PRESCALE, 1, enable cycles per count step (>=1); 1 = step on every enabled cycle
RESET_VAL, 0, value of count after rst

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
enable  in  1  step request, qualified by prescaler tick
clear  in  1  synchronous clear: count <= min
load  in  1  synchronous parallel load
load_val  in  N  value for load
up  in  1  direction, 1 = count up (WRAP/SAT; BOUNCE seed only)
mode  in  2  boundary mode, mode_t: 00 WRAP, 01 SAT, 10 BOUNCE, 11 = SAT
min  in  N  lower bound, inclusive
max  in  N  upper bound, inclusive
step  in  N  increment magnitude; 0 = hold
count  out  N  current count
at_max  out  1  comb, count == max
at_min  out  1  comb, count == min
dir_up  out  1  current effective direction
rollover  out  1  registered one-cycle boundary-event pulse
bound_err  out  1  comb, min > max

Behaviour:
- Reset (rst=1 at edge): count=RESET_VAL, dir_q=1 (UP), rollover=0, prescaler=0. rst overrides everything.
- Priority per edge: rst > clear > load > stepped enable. clear/load also zero prescaler; rollover=0 that cycle.
- load: count <= load_val clamped to [min,max].
- bound_err=1: count and dir_q hold; no step, clear or load; rollover=0.
- Prescaler: counts enabled cycles 0..PRESCALE-1; tick when count reaches PRESCALE-1 with enable=1, then restarts at 0. enable=0 freezes prescaler. PRESCALE=1: tick = enable.
- Step occurs only on tick. Arithmetic in N+1 bits: sum = count+step, diff = count-step (borrow-detected); no silent N-bit wrap.
- Out-of-range count (< min or > max, e.g. after reset or bound change) on a step: count <= min if dir up, else max; no rollover.
- dir_q: in WRAP/SAT follows up each cycle; in BOUNCE held internally, input up ignored. Entering BOUNCE keeps last dir_q. dir_up = dir_q.
- WRAP: up: sum > max -> min, rollover; else sum. Down: diff < min -> max, rollover; else diff.
- SAT: up: min(sum,max); down: max(diff,min). rollover only when count != bound and next == bound.
- BOUNCE: up: sum >= max -> count=max, dir_q=DOWN, rollover; else sum. Down: diff <= min -> count=min, dir_q=UP, rollover; else diff.
- min == max: count pinned; WRAP/BOUNCE fire rollover on every tick, SAT never.
- rollover asserted in the cycle count shows the post-event value, exactly one cycle per event.
- step == 0: count holds, no rollover.

Decomposition:
- counter_pkg: mode_t enum (MODE_WRAP, MODE_SAT, MODE_BOUNCE, MODE_RSVD), DIR_UP/DIR_DOWN constants.
- Sub-module tick_prescaler #(PRESCALE) (clk, rst, enable, restart, tick): counter width $clog2(PRESCALE)+1.
- Next-state bounds logic stays in mode_counter as one always_comb.

Test Plan:
- N=4, WRAP, up, min=2 max=9 step=3, clear then enable 4 cycles -> count 2,5,8,2; rollover high only in the cycle count=2 after 8.
- SAT, down, min=0 max=15 step=4, load 6, enable 4 cycles -> 6,2,0,0; rollover once, with first 0; at_min=1.
- BOUNCE, min=1 max=6 step=2, load 1, dir UP, enable 8 cycles -> 3,5,6,4,2,1,3,5; rollover at 6 and 1; dir_up falls at 6, rises at 1.
- PRESCALE=3, WRAP, step=1, enable held 9 cycles from 0 -> count changes every 3rd cycle: 1,2,3; enable low 2 cycles mid-run freezes phase.
- Same cycle clear=1, load=1, enable=1, min=2 -> count=2; next cycle load 12 with max=9 -> count=9; min=10 max=9 -> bound_err=1, count holds under enable.
- BOUNCE descending at count=4, rst=1 one cycle -> count=RESET_VAL(0), dir_up=1, rollover=0; next tick from out-of-range 0 with min=1 -> count=1, no rollover.
